// File: rtl/ebr_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ebr_fifo_pkg : shared defaults and types for the EBR-backed FIFO control |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package ebr_fifo_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_PAR_W  = DEF_WIDTH / 8;

  typedef logic [DEF_ADDR_W:0]   count_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_WIDTH-1:0]  word_t;
  typedef logic [DEF_PAR_W-1:0]  par_t;

endpackage
`default_nettype wire

// File: rtl/byte_parity.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_parity : per-byte even parity (XOR reduction of each byte lane)     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module byte_parity #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH/8-1:0] par
);

  generate
    for (genvar k = 0; k < WIDTH / 8; k++) begin : g_byte
      assign par[k] = ^data[8*k +: 8];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ebr_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ebr_fifo_ctrl : FIFO controller for a pseudo-dual-port EBR with byte      |
// |                 parity, level flags and sticky error reporting           |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module ebr_fifo_ctrl
  import ebr_fifo_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int AFULL_LVL  = 1016,
  parameter int AEMPTY_LVL = 8
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                Clear,
  input  logic                Push,
  input  logic [WIDTH-1:0]    PushData,
  input  logic                Pop,
  output logic [WIDTH-1:0]    PopData,
  output logic                PopValid,
  output logic                Full,
  output logic                Empty,
  output logic                AlmostFull,
  output logic                AlmostEmpty,
  output logic [ADDR_W:0]     Count,
  output logic                Overflow,
  output logic                Underflow,
  output logic                ParErr,
  output logic [ADDR_W-1:0]   ParErrAddr,
  output logic                WrEn,
  output logic [ADDR_W-1:0]   WrAddress,
  output logic [WIDTH-1:0]    Data,
  output logic [WIDTH/8-1:0]  EDI,
  output logic                RdEn,
  output logic [ADDR_W-1:0]   RdAddress,
  input  logic [WIDTH-1:0]    Q,
  input  logic [WIDTH/8-1:0]  EDO
);

  localparam int              PAR_W    = WIDTH / 8;
  localparam logic [ADDR_W:0] C_DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_AFULL  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] C_AEMPTY = (ADDR_W+1)'(AEMPTY_LVL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              pop_valid_q, pop_valid_d;
  logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              par_err_q, par_err_d;
  logic [ADDR_W-1:0] par_err_addr_q, par_err_addr_d;

  logic              push_ok;
  logic              pop_ok;
  logic [PAR_W-1:0]  edo_calc;
  logic              par_mismatch;

  // Gating with ResetN keeps the RAM strobes quiet for the whole reset window.
  assign push_ok = ResetN & Push & ~full_q & ~Clear;
  assign pop_ok  = ResetN & Pop & ~empty_q & ~Clear;

  byte_parity #(.WIDTH(WIDTH)) u_edi_gen (
    .data (PushData),
    .par  (EDI)
  );

  byte_parity #(.WIDTH(WIDTH)) u_edo_chk (
    .data (Q),
    .par  (edo_calc)
  );

  assign par_mismatch = pop_valid_q & (|(EDO ^ edo_calc));

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    pop_valid_d    = 1'b0;
    pop_addr_d     = pop_addr_q;
    ovf_d          = ovf_q;
    udf_d          = udf_q;
    par_err_d      = par_err_q;
    par_err_addr_d = par_err_addr_q;

    if (Clear) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      pop_addr_d     = '0;
      ovf_d          = 1'b0;
      udf_d          = 1'b0;
      par_err_d      = 1'b0;
      par_err_addr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        pop_addr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      pop_valid_d = pop_ok;
      ovf_d       = ovf_q | (Push & full_q);
      udf_d       = udf_q | (Pop & empty_q);
      // Only the first parity error's address is kept.
      if (par_mismatch) begin
        par_err_d = 1'b1;
        if (!par_err_q) par_err_addr_d = pop_addr_q;
      end
    end

    full_d   = (count_d == C_DEPTH);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= C_AFULL);
    aempty_d = (count_d <= C_AEMPTY);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      afull_q        <= 1'b0;
      aempty_q       <= 1'b1;
      pop_valid_q    <= 1'b0;
      pop_addr_q     <= '0;
      ovf_q          <= 1'b0;
      udf_q          <= 1'b0;
      par_err_q      <= 1'b0;
      par_err_addr_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      afull_q        <= afull_d;
      aempty_q       <= aempty_d;
      pop_valid_q    <= pop_valid_d;
      pop_addr_q     <= pop_addr_d;
      ovf_q          <= ovf_d;
      udf_q          <= udf_d;
      par_err_q      <= par_err_d;
      par_err_addr_q <= par_err_addr_d;
    end
  end

  assign WrEn        = push_ok;
  assign WrAddress   = wr_ptr_q;
  assign Data        = PushData;
  assign RdEn        = pop_ok;
  assign RdAddress   = rd_ptr_q;
  assign PopData     = Q;
  assign PopValid    = pop_valid_q;
  assign Count       = count_q;
  assign Full        = full_q;
  assign Empty       = empty_q;
  assign AlmostFull  = afull_q;
  assign AlmostEmpty = aempty_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;
  assign ParErr      = par_err_q;
  assign ParErrAddr  = par_err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ebr_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ebr_fifo_ctrl : self-checking bench with RAM model and FIFO scoreboard |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_ebr_fifo_ctrl;
  import ebr_fifo_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int W     = DEF_WIDTH;
  localparam int PW    = DEF_PAR_W;
  localparam int DEPTH = 1 << AW;
  localparam int AFL   = 1016;
  localparam int AEL   = 8;

  logic          Clock, ResetN, Clear, Push, Pop;
  word_t         PushData, PopData, Data, Q;
  logic          PopValid, Full, Empty, AlmostFull, AlmostEmpty;
  count_t        Count;
  logic          Overflow, Underflow, ParErr;
  addr_t         ParErrAddr, WrAddress, RdAddress;
  logic          WrEn, RdEn;
  par_t          EDI, EDO;

  ebr_fifo_ctrl #(
    .ADDR_W(AW), .WIDTH(W), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .Clear(Clear),
    .Push(Push), .PushData(PushData), .Pop(Pop),
    .PopData(PopData), .PopValid(PopValid),
    .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow),
    .ParErr(ParErr), .ParErrAddr(ParErrAddr),
    .WrEn(WrEn), .WrAddress(WrAddress), .Data(Data), .EDI(EDI),
    .RdEn(RdEn), .RdAddress(RdAddress), .Q(Q), .EDO(EDO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model; optionally corrupts EDO[2] for words at addresses 5 and 9
  word_t mem     [DEPTH];
  par_t  par_mem [DEPTH];
  bit    flip_en;

  always @(posedge Clock) begin
    if (WrEn) begin
      mem[WrAddress]     <= Data;
      par_mem[WrAddress] <= EDI;
    end
    if (RdEn) begin
      Q   <= mem[RdAddress];
      EDO <= par_mem[RdAddress] ^
             ((flip_en && (RdAddress == addr_t'(5) || RdAddress == addr_t'(9))) ? par_t'(4'b0100) : par_t'(0));
    end
  end

  // Reference model state
  word_t model[$];
  word_t sb[$];
  addr_t exp_wptr, exp_rptr, exp_pe_addr, pend_addr;
  bit    exp_ovf, exp_udf, exp_pe, exp_pv, pend_pe;
  int    n_checks, n_errors;

  typedef struct {
    bit    push;
    bit    pop;
    word_t data;
    int    exp_count;
  } vec_t;
  vec_t tbl[7];

  function automatic par_t par_of(input word_t d);
    par_t r;
    for (int k = 0; k < PW; k++) r[k] = ^d[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model.delete();
    sb.delete();
    exp_wptr = '0; exp_rptr = '0; exp_pe_addr = '0; pend_addr = '0;
    exp_ovf = 0; exp_udf = 0; exp_pe = 0; exp_pv = 0; pend_pe = 0;
  endtask

  task automatic check_state();
    word_t w;
    chk("PopValid", PopValid, exp_pv);
    if (exp_pv && sb.size() > 0) begin
      w = sb.pop_front();
      chk("PopData", PopData, w);
    end
    chk("Count", Count, model.size());
    chk("Empty", Empty, model.size() == 0);
    chk("Full", Full, model.size() == DEPTH);
    chk("AlmostFull", AlmostFull, model.size() >= AFL);
    chk("AlmostEmpty", AlmostEmpty, model.size() <= AEL);
    chk("Overflow", Overflow, exp_ovf);
    chk("Underflow", Underflow, exp_udf);
    chk("ParErr", ParErr, exp_pe);
    chk("ParErrAddr", ParErrAddr, exp_pe_addr);
  endtask

  // One clock of stimulus: inputs driven just after a rising edge, strobes
  // checked mid-cycle, registered state checked just after the next edge.
  task automatic step(input bit push, input bit pop, input bit clr, input word_t d);
    bit    push_acc, pop_acc, full_m, empty_m;
    word_t w;
    Push = push; Pop = pop; Clear = clr; PushData = d;
    full_m   = (model.size() == DEPTH);
    empty_m  = (model.size() == 0);
    push_acc = push && !clr && !full_m;
    pop_acc  = pop && !clr && !empty_m;
    #1;
    chk("WrEn", WrEn, push_acc);
    chk("RdEn", RdEn, pop_acc);
    if (push_acc) begin
      chk("WrAddress", WrAddress, exp_wptr);
      chk("Data", Data, d);
      chk("EDI", EDI, par_of(d));
    end
    if (pop_acc) chk("RdAddress", RdAddress, exp_rptr);
    @(posedge Clock);
    if (clr) begin
      model_reset();
    end else begin
      if (pend_pe) begin
        if (!exp_pe) exp_pe_addr = pend_addr;
        exp_pe = 1;
      end
      pend_pe = 0;
      if (push && full_m) exp_ovf = 1;
      if (pop && empty_m) exp_udf = 1;
      exp_pv = pop_acc;
      if (pop_acc) begin
        w = model.pop_front();
        sb.push_back(w);
        if (flip_en && (exp_rptr == addr_t'(5) || exp_rptr == addr_t'(9))) begin
          pend_pe   = 1;
          pend_addr = exp_rptr;
        end
        exp_rptr++;
      end
      if (push_acc) begin
        model.push_back(d);
        exp_wptr++;
      end
    end
    #1;
    check_state();
  endtask

  task automatic do_reset();
    ResetN = 1'b0; Push = 1'b1; Pop = 1'b1; Clear = 1'b0; PushData = 32'hDEAD_BEEF;
    #1;
    chk("rst_WrEn", WrEn, 1'b0);
    chk("rst_RdEn", RdEn, 1'b0);
    chk("rst_PopValid", PopValid, 1'b0);
    @(posedge Clock); #1;
    Push = 1'b0; Pop = 1'b0;
    model_reset();
    check_state();
    @(posedge Clock); #2;
    ResetN = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; flip_en = 0;
    Clear = 0; Push = 0; Pop = 0; PushData = '0; ResetN = 1'b0;
    model_reset();

    tbl[0] = '{1, 0, 32'h1111_1111, 1};
    tbl[1] = '{1, 0, 32'h2222_2222, 2};
    tbl[2] = '{1, 0, 32'h3333_3333, 3};
    tbl[3] = '{0, 1, 32'h0,         2};
    tbl[4] = '{0, 1, 32'h0,         1};
    tbl[5] = '{0, 1, 32'h0,         0};
    tbl[6] = '{0, 0, 32'h0,         0};

    do_reset();

    // Basic ordering and latency
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].push, tbl[i].pop, 1'b0, tbl[i].data);
      chk("tbl_count", Count, tbl[i].exp_count);
    end

    // Fill to full, then a push+pop at full
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, $urandom());
    chk("full_flag", Full, 1'b1);
    chk("full_count", Count, 11'd1024);
    step(1, 1, 0, 32'hBAD0_BAD0);
    chk("ovf_flag", Overflow, 1'b1);
    chk("ovf_count", Count, 11'd1023);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // Pop while empty with a simultaneous push
    step(1, 1, 0, 32'hA5A5_5A5A);
    chk("udf_flag", Underflow, 1'b1);
    chk("udf_count", Count, 11'd1);

    // Pointer wrap with interleaved traffic
    step(0, 0, 1, '0);
    step(1, 0, 0, $urandom());
    for (int i = 1; i < 1030; i++) step(1, 1, 0, $urandom());
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("wrap_wptr", WrAddress, 10'd6);

    // Parity corruption at addresses 5 and 9
    step(0, 0, 1, '0);
    flip_en = 1;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 32'h0101_0000 * i + 32'h0000_00F0 + i);
    for (int i = 0; i < 7; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("pe_first", ParErr, 1'b1);
    chk("pe_addr_first", ParErrAddr, 10'd5);
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("pe_addr_held", ParErrAddr, 10'd5);
    flip_en = 0;

    // Clear beats Push/Pop at Count=7 with sticky flags set
    step(0, 1, 0, '0);
    chk("pre_clr_udf", Underflow, 1'b1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, $urandom());
    chk("pre_clr_count", Count, 11'd7);
    step(1, 1, 1, 32'hCAFE_F00D);
    chk("clr_count", Count, 11'd0);
    chk("clr_empty", Empty, 1'b1);
    chk("clr_udf", Underflow, 1'b0);
    chk("clr_pe", ParErr, 1'b0);
    chk("clr_pe_addr", ParErrAddr, 10'd0);

    // Reset pulse right after an accepted pop
    for (int i = 0; i < 4; i++) step(1, 0, 0, $urandom());
    step(0, 1, 0, '0);
    do_reset();
    step(0, 0, 0, '0);
    chk("post_rst_count", Count, 11'd0);
    step(1, 0, 0, 32'h7777_0000);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ebr_fifo_ctrl.md
EBR_FIFO_CTRL -- requirements
Module: ebr_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning RAM address width (depth 2**ADDR_W = 1024).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning data width (multiple of 8).
REQ-003 The block SHALL have parameter AFULL_LVL, default 1016, meaning AlmostFull threshold (Count >= AFULL_LVL).
REQ-004 The block SHALL have parameter AEMPTY_LVL, default 8, meaning AlmostEmpty threshold (Count <= AEMPTY_LVL).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: Clock  in  1  single clock; the RAM RdClock and WrClock are tied to it.
REQ-006 ResetN  in  1  asynchronous active-low reset.
REQ-007 Clear  in  1  synchronous flush.
REQ-008 Push  in  1  write request; PushData  in  WIDTH  write word.
REQ-009 Pop  in  1  read request; PopData  out  WIDTH  read word; PopValid  out  1  PopData qualifier.
REQ-010 Full, Empty, AlmostFull, AlmostEmpty  out  1 each  level flags; Count  out  ADDR_W+1  occupancy.
REQ-011 Overflow, Underflow, ParErr  out  1 each  sticky errors; ParErrAddr  out  ADDR_W  address of the first parity error.
REQ-012 RAM write side: WrEn  out  1; WrAddress  out  ADDR_W; Data  out  WIDTH; EDI  out  WIDTH/8.
REQ-013 RAM read side: RdEn  out  1; RdAddress  out  ADDR_W; Q  in  WIDTH; EDO  in  WIDTH/8.

Function
REQ-014 A push SHALL be accepted when Push=1, Full=0 and Clear=0; acceptance drives WrEn=1, WrAddress=wr_ptr and Data=PushData combinationally in the same cycle, and increments wr_ptr.
REQ-015 EDI[k] SHALL be the XOR of Data[8k+7:8k] (even parity per byte).
REQ-016 A pop SHALL be accepted when Pop=1, Empty=0 and Clear=0; acceptance drives RdEn=1 and RdAddress=rd_ptr in the same cycle, and increments rd_ptr.
REQ-017 PopValid SHALL be 1 exactly one cycle after each accepted pop; PopData SHALL equal Q, so read latency is 1 cycle.
REQ-018 Pointers SHALL wrap from 2**ADDR_W-1 to 0.
REQ-019 Count SHALL be +1 on a push only, -1 on a pop only, and unchanged on push and pop together; Count is registered.
REQ-020 Full SHALL be (Count == 2**ADDR_W) and Empty SHALL be (Count == 0); AlmostFull and AlmostEmpty SHALL follow REQ-003/REQ-004; all four flags are registered from the next-state Count.
REQ-021 A push while Full SHALL be rejected even if a pop is accepted in the same cycle, and SHALL set Overflow.
REQ-022 A pop while Empty SHALL be rejected even if a push is accepted in the same cycle, and SHALL set Underflow; no RAM read-during-write to the same address can therefore occur.
REQ-023 On a PopValid cycle, if any EDO[k] differs from the XOR of Q byte k, the block SHALL set ParErr; if ParErr was previously 0, it SHALL capture into ParErrAddr the address popped in the prior cycle.
REQ-024 Overflow, Underflow, ParErr and ParErrAddr SHALL hold until Clear or reset.
REQ-025 Clear SHALL take priority over Push and Pop: in the next cycle pointers, Count and sticky flags are 0, PopValid is 0, and WrEn and RdEn are 0 in the Clear cycle.
REQ-026 RAM contents SHALL NOT be initialised by the block.

Reset
REQ-027 While ResetN=0, the block SHALL hold: pointers=0, Count=0, Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0, PopValid=0, Overflow=0, Underflow=0, ParErr=0, ParErrAddr=0, WrEn=0, RdEn=0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight pop, with no PopValid after release; the first push after release goes to address 0.

Structure
REQ-029 Package ebr_fifo_pkg SHALL hold the ADDR_W, WIDTH and PAR_W (=WIDTH/8) defaults and the count/address typedefs.
REQ-030 Sub-module byte_parity (combinational WIDTH -> WIDTH/8 XOR reduction) SHALL be instantiated twice: once for EDI generation and once for the EDO check.

Verification
REQ-031 The bench SHALL cover: after reset, push 0x11111111, 0x22222222, 0x33333333, then 3 pops -> PopData is the same sequence one cycle after each pop, and Count returns 3 -> 0.
REQ-032 The bench SHALL cover: 1024 pushes -> Full=1 and Count=1024; a 1025th push with a simultaneous pop -> push rejected, Overflow=1, Count=1023.
REQ-033 The bench SHALL cover: pop when Empty with a simultaneous push -> Underflow=1, RdEn=0, Count=1; wrap case with 1030 pushes and pops interleaved -> WrAddress goes 1023 -> 0 and data stays intact.
REQ-034 The bench SHALL cover: the RAM model flips EDO[2] on the word at address 5 -> ParErr=1 and ParErrAddr=5; a later error at address 9 leaves ParErrAddr=5.
REQ-035 The bench SHALL cover: Clear asserted with Push=Pop=1 at Count=7 -> WrEn=RdEn=0, next cycle Count=0, Empty=1, flags cleared.
REQ-036 The bench SHALL cover: ResetN pulsed low the cycle after an accepted pop -> no PopValid, Count=0, and the next push writes address 0.
